// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared types and RV32I decode constants for the ysyx_22041211 prefetching IFU.
// rv_illegal() is only instantiated when YSYX_22041211_IFU_ILLEGAL_CHK_EN is defined.
package ysyx_22041211_ifu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ifu_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_B     = 3'b000;
    localparam logic [2:0] F3_H     = 3'b001;
    localparam logic [2:0] F3_W     = 3'b010;
    localparam logic [2:0] F3_BU    = 3'b100;
    localparam logic [2:0] F3_HU    = 3'b101;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;

    localparam logic [6:0]  F7_BASE = 7'b0000000;
    localparam logic [6:0]  F7_ALT  = 7'b0100000;
    localparam logic [31:0] W_ECALL  = 32'h0000_0073;
    localparam logic [31:0] W_EBREAK = 32'h0010_0073;
    localparam logic [31:0] W_MRET   = 32'h3020_0073;

    // Returns 1 when the word falls outside the subset the core executes.
    function automatic logic rv_illegal(input logic [31:0] w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       legal;
        opc   = w[6:0];
        f3    = w[14:12];
        f7    = w[31:25];
        legal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            OPC_JALR:   legal = (f3 == 3'b000);
            OPC_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
            OPC_LOAD:   legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                                (f3 == F3_BU) || (f3 == F3_HU);
            OPC_STORE:  legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
            OPC_OPIMM: begin
                if (f3 == F3_SLL)     legal = (f7 == F7_BASE);
                else if (f3 == F3_SR) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else                  legal = 1'b1;
            end
            OPC_OP:     legal = (f7 == F7_BASE) ||
                                ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            OPC_SYSTEM: legal = (f3 == F3_CSRRW) || (f3 == F3_CSRRS) ||
                                (w == W_ECALL) || (w == W_EBREAK) || (w == W_MRET);
            default:    legal = 1'b0;
        endcase
        return ~legal;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_fifo.sv
// Synchronous FIFO with flush for prefetched entries; storage resets to RST_VAL
// so the head fields show a defined value before the first enqueue.
module ysyx_22041211_ifu_fifo #(
    parameter int            W       = 8,
    parameter int            DEPTH   = 4,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [W-1:0]              din_i,
    input  logic                      pop_i,
    output logic [W-1:0]              dout_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Push while full is accepted only together with a pop.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ysyx_22041211_ifu_pf.sv
// Prefetching IFU: pipelined in-order word fetches into a small queue feeding the IDU.
// Define YSYX_22041211_IFU_ILLEGAL_CHK_EN to decode each word for inst_illegal_o.
module ysyx_22041211_ifu_pf
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
    input  logic                  mem_resp_err_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  inst_fault_o,
    output logic                  inst_illegal_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH + 2;

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // valid never waits on ready, and a redirect cycle voids the IDU-side transfer.
    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [EW-1:0]         enq_entry, head_entry;
    logic [CW:0]           inflight;
    logic                  credit_ok, req_fire, enq, deq, enq_illegal;
    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc_i & ~ADDR_WIDTH'(3);

    // Responses still owed to the memory (including ones to be dropped) consume credit.
    assign inflight  = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok = ~fifo_full & (inflight < (CW+1)'(FIFO_DEPTH));

    assign mem_req_valid_o = (state_q == ST_RUN) & ~redirect_valid_i & credit_ok;
    assign mem_req_addr_o  = fpc_q;
    assign req_fire        = mem_req_valid_o & mem_req_ready_i;

    assign enq = mem_resp_valid_i & ~redirect_valid_i & (drop_q == '0);
    assign deq = inst_valid_o & inst_ready_i;

`ifdef YSYX_22041211_IFU_ILLEGAL_CHK_EN
    assign enq_illegal = ~mem_resp_err_i & rv_illegal(mem_resp_data_i[31:0]);
`else
    assign enq_illegal = 1'b0;
`endif

    assign enq_entry = {resp_pc_q,
                        mem_resp_err_i ? {DATA_WIDTH{1'b0}} : mem_resp_data_i,
                        mem_resp_err_i,
                        enq_illegal};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (enq && mem_resp_err_i) state_d = ST_HALT;
            ST_HALT: if (redirect_valid_i) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fpc_d     = fpc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q + CW'(req_fire) - CW'(mem_resp_valid_i);
        drop_d    = drop_q;
        if (redirect_valid_i) begin
            fpc_d     = redirect_pc_aligned;
            resp_pc_d = redirect_pc_aligned;
            drop_d    = outst_q - CW'(mem_resp_valid_i);
        end else begin
            if (req_fire) fpc_d = fpc_q + ADDR_WIDTH'(4);
            if (enq) resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
            if (mem_resp_valid_i && drop_q != '0) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            fpc_q     <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    ysyx_22041211_ifu_fifo #(
        .W       (EW),
        .DEPTH   (FIFO_DEPTH),
        .RST_VAL ({RESET_PC, {DATA_WIDTH{1'b0}}, 2'b00})
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid_i),
        .push_i  (enq),
        .din_i   (enq_entry),
        .pop_i   (deq),
        .dout_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign inst_valid_o = ~fifo_empty;
    assign {pc_o, inst_o, inst_fault_o, inst_illegal_o} = head_entry;

endmodule

// File: tb/tb_ysyx_22041211_ifu_pf.sv
// Bench for ysyx_22041211_ifu_pf: randomized memory/IDU stimulus checked every cycle
// against a queue-level reference model of the fetch stream.
module tb_ysyx_22041211_ifu_pf;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        mem_resp_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_fault_o;
    logic        inst_illegal_o;

    ysyx_22041211_ifu_pf dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .inst_fault_o     (inst_fault_o),
        .inst_illegal_o   (inst_illegal_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] real_addr;
        logic [31:0] exp_addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [65:0] exp_q[$];   // {pc, inst, fault, illegal}
    logic [31:0] m_fpc;
    int          m_outst;
    bit          m_boot, m_halt;
    int          cyc;

    int          lat_min = 1, lat_max = 1, resp_pct = 100;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;

    int          n_cmp = 0, n_fail = 0;
    int          first_req, first_val, n_acc;
    bit          watch_req, watch_deq, watch_fault;
    logic [31:0] seen_req, seen_pc, seen_fault_pc, seen_fault_inst;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h8000_0010: return 32'h0000_0000;
            32'h8000_0014: return 32'h0010_0093;
            32'h8000_0018: return 32'h3020_0073;
            32'h8000_001c: return 32'h4000_5013;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    function automatic bit err_at(input logic [31:0] a);
        return err_en && (a == err_addr);
    endfunction

    function automatic bit ref_illegal(input logic [31:0] w);
`ifdef YSYX_22041211_IFU_ILLEGAL_CHK_EN
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        if (w == 32'h0000_0073 || w == 32'h0010_0073 || w == 32'h3020_0073) return 1'b0;
        case (w[6:0])
            7'h37, 7'h17, 7'h6f: return 1'b0;
            7'h67: return f3 != 3'd0;
            7'h63: return f3 == 3'd2 || f3 == 3'd3;
            7'h03: return f3 == 3'd3 || f3 >= 3'd6;
            7'h23: return f3 > 3'd2;
            7'h13: begin
                if (f3 == 3'd1) return f7 != 7'h00;
                if (f3 == 3'd5) return !(f7 == 7'h00 || f7 == 7'h20);
                return 1'b0;
            end
            7'h33: return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            7'h73: return !(f3 == 3'd1 || f3 == 3'd2);
            default: return 1'b1;
        endcase
`else
        return w == 32'hFFFF_FFFF && w != 32'hFFFF_FFFF;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst              = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        inst_ready_i     = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        mem_resp_err_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_req_valid", 66'(mem_req_valid_o), 66'(0));
        check("rst_inst_valid", 66'(inst_valid_o), 66'(0));
        check("rst_head", {pc_o, inst_o, inst_fault_o, inst_illegal_o}, {RESET_PC, 32'h0, 2'b00});
        mem_q.delete();
        exp_q.delete();
        m_fpc     = RESET_PC;
        m_outst   = 0;
        m_boot    = 1'b1;
        m_halt    = 1'b0;
        cyc       = 0;
        first_req = -1;
        first_val = -1;
        n_acc     = 0;
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit irdy, input bit mrdy);
        bit          resp, exp_rv, acc, m_acc, deq;
        logic [31:0] req_addr;
        mreq_t       h;
        @(negedge clk);
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        inst_ready_i     = irdy;
        mem_req_ready_i  = mrdy;
        resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < resp_pct);
        mem_resp_valid_i = resp;
        mem_resp_data_i  = resp ? word_at(mem_q[0].real_addr) : $urandom;
        mem_resp_err_i   = resp ? err_at(mem_q[0].real_addr) : 1'($urandom_range(1));
        #1;
        exp_rv = !m_boot && !m_halt && !redir && (m_outst + exp_q.size() < DEPTH);
        check("req_valid", 66'(mem_req_valid_o), 66'(exp_rv));
        if (exp_rv) check("req_addr", 66'(mem_req_addr_o), 66'(m_fpc));
        check("inst_valid", 66'(inst_valid_o), 66'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("head", {pc_o, inst_o, inst_fault_o, inst_illegal_o}, exp_q[0]);

        acc      = mem_req_valid_o && mrdy;
        req_addr = mem_req_addr_o;
        m_acc    = exp_rv && mrdy;
        deq      = (exp_q.size() != 0) && irdy && !redir;
        if (acc) n_acc++;
        if (acc && first_req < 0) first_req = cyc;
        if (inst_valid_o && first_val < 0) first_val = cyc;
        if (acc && watch_req) begin seen_req = req_addr; watch_req = 1'b0; end
        if (inst_valid_o && irdy && !redir && watch_deq) begin seen_pc = pc_o; watch_deq = 1'b0; end
        if (inst_valid_o && inst_fault_o && watch_fault) begin
            seen_fault_pc = pc_o; seen_fault_inst = inst_o; watch_fault = 1'b0;
        end

        @(posedge clk);
        if (deq) void'(exp_q.pop_front());
        if (resp) begin
            h = mem_q.pop_front();
            m_outst--;
            if (!h.stale && !redir) begin
                logic e;
                e = err_at(h.exp_addr);
                exp_q.push_back({h.exp_addr, e ? 32'h0 : word_at(h.exp_addr), e,
                                 e ? 1'b0 : ref_illegal(word_at(h.exp_addr))});
                if (e) m_halt = 1'b1;
            end
        end
        if (acc) mem_q.push_back('{real_addr: req_addr, exp_addr: m_fpc,
                                   due: cyc + $urandom_range(lat_max, lat_min), stale: 1'b0});
        if (m_acc) begin
            m_fpc += 32'd4;
            m_outst++;
        end
        if (redir) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_q.delete();
            m_fpc  = rpc & ~32'd3;
            m_halt = 1'b0;
        end
        m_boot = 1'b0;
        cyc++;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        watch_req   = 1'b0;
        watch_deq   = 1'b0;
        watch_fault = 1'b0;
        seen_req    = '0;
        seen_pc     = '0;
        seen_fault_pc   = '0;
        seen_fault_inst = '1;

        // Streaming with a 1-cycle memory.
        do_reset();
        repeat (20) cycle(1'b0, '0, 1'b1, 1'b1);
        check("first_req_cycle", 66'(first_req), 66'(1));
        check("first_valid_cycle", 66'(first_val), 66'(3));

        // IDU stalled: only FIFO_DEPTH requests fit.
        do_reset();
        repeat (12) cycle(1'b0, '0, 1'b0, 1'b1);
        check("stall_requests", 66'(n_acc), 66'(DEPTH));
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);

        // Redirect with responses in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 32'h8000_0102, 1'b1, 1'b1);
        watch_req = 1'b1; watch_deq = 1'b1;
        repeat (14) cycle(1'b0, '0, 1'b1, 1'b1);
        check("redir_first_req", 66'(seen_req), 66'(32'h8000_0100));
        check("redir_first_pc", 66'(seen_pc), 66'(32'h8000_0100));

        // Access fault halts fetching until a redirect.
        do_reset();
        lat_min = 1; lat_max = 1;
        err_en = 1'b1; err_addr = 32'h8000_0008;
        watch_fault = 1'b1;
        repeat (15) cycle(1'b0, '0, 1'b1, 1'b1);
        check("fault_requests", 66'(n_acc), 66'(4));
        check("fault_pc", 66'(seen_fault_pc), 66'(32'h8000_0008));
        check("fault_inst", 66'(seen_fault_inst), 66'(0));
        err_en = 1'b0;
        cycle(1'b1, 32'h8000_0040, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

        // Redirect landing on a response and a dequeue together.
        cycle(1'b1, 32'h8000_0200, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic with redirects, faults and occasional resets.
        lat_min = 1; lat_max = 4; resp_pct = 70;
        err_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) err_addr = RESET_PC + 32'(4 * $urandom_range(80));
            if ($urandom_range(999) < 3) do_reset();
            else cycle($urandom_range(99) < 3, RESET_PC + 32'($urandom_range(255)),
                       $urandom_range(99) < 70, $urandom_range(99) < 70);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_ifu_pf.md
# ysyx_22041211_ifu_pf

Prefetching instruction fetch unit for the ysyx_22041211 core. It sits between the PC-redirect sources (branch, jump and CSR trap/mret, already arbitrated into one redirect) and the IDU. It issues pipelined, in-order word fetches to the instruction memory port. Returned words are buffered in a FIFO_DEPTH-entry queue and presented to the IDU over a valid/ready handshake. A redirect flushes the queue and discards any in-flight responses.

## Interface
- ADDR_WIDTH, 32, fetch address width
- DATA_WIDTH, 32, instruction width
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- RESET_PC, 32'h8000_0000, first fetch address
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid_i  in  1  flush and restart at redirect_pc_i
- redirect_pc_i  in  ADDR_WIDTH  new fetch PC; bits [1:0] forced to 0
- mem_req_valid_o  out  1  fetch request
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  fetch address
- mem_resp_valid_i  in  1  in-order response
- mem_resp_data_i  in  DATA_WIDTH  fetched word
- mem_resp_err_i  in  1  access fault for this response
- inst_valid_o  out  1  head entry valid
- inst_ready_i  in  1  IDU consumes head
- inst_o  out  DATA_WIDTH  head instruction; 0 on fault
- pc_o  out  ADDR_WIDTH  head PC
- inst_fault_o  out  1  head carries access fault
- inst_illegal_o  out  1  head not in supported ISA subset (see Configuration)

## Operation
- Three-state FSM:
  - BOOT: entered on reset; lasts 1 cycle, then RUN.
  - RUN: normal fetching.
  - HALT: entered when a fault response is enqueued; no requests issued. Exits to RUN only on redirect.
- Fetch PC register (fpc):
  - RESET_PC on reset.
  - +4 on each accepted request (valid & ready). Wraps modulo 2^ADDR_WIDTH.
  - Set to redirect_pc_i & ~3 on redirect.
- mem_req_valid_o = (state==RUN) & ~redirect_valid_i & (outstanding + fifo_count < FIFO_DEPTH).
  - Credit includes responses still to be dropped.
  - mem_req_addr_o = fpc.
- outstanding counter:
  - +1 on accepted request.
  - −1 on each response.
- Per-entry PC is tracked by an issue-PC queue (or equivalent) so that pc_o matches the request address.
- Redirect in cycle N:
  - FIFO emptied at end of N.
  - drop_cnt ← outstanding − (mem_resp_valid_i in N).
  - The next drop_cnt responses are discarded without enqueue.
- Handshake:
  - Dequeue on inst_valid_o & inst_ready_i.
  - inst_valid_o is not gated by redirect_valid_i. The IDU ignores any transfer it makes in a redirect cycle.
- Simultaneous enqueue and dequeue with the FIFO full is legal. The credit rule guarantees no overflow.
- A response arriving while drop_cnt>0 is discarded regardless of mem_resp_err_i.

## Timing
- Reset values:
  - mem_req_valid_o=0, inst_valid_o=0, inst_fault_o=0, inst_illegal_o=0.
  - inst_o=0, pc_o=RESET_PC, FIFO empty, counters 0.
- The first request appears in the cycle after BOOT, i.e. the 2nd cycle after rst deasserts.
- Response in cycle M is enqueued at the end of M. inst_valid_o rises in M+1. Best case is request N → response N+1 → inst_valid_o N+2.
- Throughput is 1 instruction/cycle when memory returns one response per cycle.
- rst mid-operation overrides everything: in-flight responses after reset are not tracked. The memory model must be reset together with this block.

## Configuration
- YSYX_22041211_IFU_ILLEGAL_CHK_EN defined:
  - At enqueue, the word is decoded against the supported set: LUI, AUIPC, JAL, JALR, BRANCH; LB/LH/LW/LBU/LHU; SB/SH/SW; OP-IMM incl. SLLI/SRLI/SRAI; OP; CSRRW/CSRRS; ECALL, EBREAK, MRET.
  - The result is stored per entry as inst_illegal_o. Faulted entries report illegal=0.
- Undefined: inst_illegal_o is tied to 0 and no decode logic is built.

## Structure
- Package ysyx_22041211_ifu_pkg holds:
  - the FSM state enum (BOOT/RUN/HALT);
  - opcode and funct3 constants for the legality check.
- Sub-module ysyx_22041211_ifu_fifo: parametric synchronous FIFO with flush. Entry is {pc, inst, fault, illegal}; outputs count, full, empty.

## Test plan
- Reset, memory always ready with 1-cycle latency → requests to 0x80000000, 0x80000004, …; inst_valid_o first high 2 cycles after the first request; pc_o increments by 4 each cycle.
- inst_ready_i=0 for 10 cycles → exactly FIFO_DEPTH requests issued, then mem_req_valid_o=0 until a dequeue.
- Redirect to 0x80000102 with 3 responses in flight → those 3 are dropped; the next request is 0x80000100; the first delivered pc_o is 0x80000100.
- Response with mem_resp_err_i=1 at 0x80000008 → that entry shows inst_fault_o=1, inst_o=0; no further requests until redirect.
- Illegal check enabled, word 0x0000_0000 → inst_illegal_o=1; word 0x0010_0093 (addi) → 0.
- Redirect coinciding with a response and a dequeue → response dropped, FIFO empty next cycle, drop_cnt correct.
